blink_meter: RTL and testbench
==============================

# blink_meter

Measurement receiver for the blink waveforms the blinker stage generates from the free-running counter. It takes a single blink line, synchronises it, detects edges, and reports the period and high time of each complete cycle in clock cycles. It sits on the input side of the design, so a blink produced by another tile or by an offset blinker can be checked or decoded against the local clock.

## Interface
Parameters:
- `WIDTH`, default 16: width of the measurement counter and of the result registers. Matches the `currentCount` width.
- `SYNC_STAGES`, default 2 (minimum 2): number of input synchroniser flops.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `blink_in`, in, 1: blink waveform to measure. It may be asynchronous to `clk`.
- `period`, out, WIDTH: cycles between the last two qualified rising edges.
- `high_time`, out, WIDTH: cycles from the earlier of those rising edges to the falling edge between them.
- `meas_valid`, out, 1: one-cycle pulse when `period` and `high_time` update.
- `locked`, out, 1: at least one valid measurement has completed since the last reset or timeout.
- `timeout`, out, 1: sticky flag. Set when a level persists longer than the counter range; cleared by reset or by the next `meas_valid`.

## Operation
- Synchroniser: `blink_in` passes through a chain of `SYNC_STAGES` flops, all reset to 0. The last stage is `s`. A further flop `s_d` holds `s` delayed by one cycle and also resets to 0.
- Edge detect (combinational): `rise = s & ~s_d`, `fall = ~s & s_d`. Rise and fall are mutually exclusive.
- Internal counter `cnt` is WIDTH bits wide.
- States:
  - ARM: wait for `s`=0, then go to WAIT_RISE. This state blocks a spurious rise when the line is already high at reset release or after a timeout.
  - WAIT_RISE: on `rise`, set `cnt`<=1 and go to HIGH.
  - HIGH: `cnt`<=`cnt`+1. On `fall`, latch `hi_lat`<=`cnt` and go to LOW.
  - LOW: `cnt`<=`cnt`+1. On `rise`, the following all happen:
    - `period`<=`cnt` and `high_time`<=`hi_lat`.
    - `meas_valid`<=1, `locked`<=1, `timeout`<=0.
    - `cnt`<=1 and go to HIGH.
- Result: for an input with period P and high time H cycles, `period`=P and `high_time`=H.
- Timeout: in HIGH or LOW, if `cnt` equals all-ones and no terminating edge is seen that cycle:
  - `timeout`<=1 and `locked`<=0.
  - Go to ARM.
  - `period` and `high_time` keep their last values.
  - If the terminating edge arrives in the same cycle that `cnt` is all-ones, the edge wins. The maximum reportable value is 2^WIDTH-1.
- A one-cycle pulse on `s` is legal and measures as `high_time`=1.
- Reset values:
  - `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, `timeout`=0.
  - `cnt`=0, `hi_lat`=0, synchroniser and `s_d` all 0.
  - State ARM.
- Reset mid-measurement abandons the measurement in progress. The first report after reset needs a low level and then two rising edges.

## Timing
- Let edge k be the first clock edge that samples a new level on `blink_in`. `s` shows that level after edge k+SYNC_STAGES-1, and `rise`/`fall` are asserted in that cycle.
- `meas_valid`, `period`, `high_time`, `locked`, and the clearing of `timeout` all become visible after edge k+SYNC_STAGES. Total latency is SYNC_STAGES+1 edges from sampling.
- `meas_valid` is high for exactly one cycle per completed period. Consecutive pulses are spaced exactly P cycles apart for a steady input.
- `timeout` and the `locked` clear become visible the cycle after the overflow cycle.
- Reset takes effect at the first rising edge with `rst`=1. All outputs are at their reset values in the following cycle and stay there while `rst` is held.

## Test plan
All scenarios use WIDTH=16 and SYNC_STAGES=2 unless stated otherwise.

1. Reset with `blink_in`=0, then drive a square wave with period 10 and high time 3.
   - Required: the first `meas_valid` comes 3 edges after sampling the second rising input edge, with `period`=10, `high_time`=3 and `locked`=1.
   - Required: later pulses arrive every 10 cycles with the same values.
2. Hold `blink_in`=1 through reset and for 20 cycles after it, then drive period 8 / high 4.
   - Required: no report derived from the initial high.
   - Required: the first `meas_valid` shows 8/4.
3. Use WIDTH=8. Lock on period 10 / high 5, then hold `blink_in` high.
   - Required: `timeout`=1 and `locked`=0 once `cnt` reaches 255.
   - Required: `period`=10 and `high_time`=5 are retained.
   - Then resume the wave. Required: the next valid report clears `timeout`.
4. Switch from period 10 / high 3 to period 6 / high 1.
   - Required: the first report after the switch that covers a full new cycle shows 6/1.
   - Required: no report shows a value other than 10/3 or 6/1.
5. Assert `rst` for 1 cycle while in HIGH.
   - Required: next cycle all outputs are 0.
   - Required: no `meas_valid` until a low level and two new rising edges have been seen, after which the correct values are reported.
6. Drive a 1-cycle-high pulse train with period 4.
   - Required: `high_time`=1 and `period`=4 on every report, with no missed edges.

Source files
------------

// File: rtl/blink_meter.sv
// Blink waveform receiver: synchronises blink_in and reports the period and
// high time of each complete cycle, counted in clk cycles.
module blink_meter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    ARM,
    WAIT_RISE,
    HIGH,
    LOW
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       hi_lat;
  logic                   cnt_full;
  logic                   cnt_load;
  logic                   cnt_inc;
  logic                   hi_load;
  logic                   report;
  logic                   overflow;

  assign s        = sync[SYNC_STAGES-1];
  assign rise     = s & ~s_d;
  assign fall     = ~s & s_d;
  assign cnt_full = &cnt;

  // fill marks when the chain holds real samples rather than its reset zeros,
  // so a line held high across reset release cannot arm on the flushed zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      fill <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], blink_in};
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
      s_d  <= s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    hi_load    = 1'b0;
    report     = 1'b0;
    overflow   = 1'b0;
    case (state)
      ARM: begin
        if (fill[SYNC_STAGES-1] && !s) begin
          state_next = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          cnt_load   = 1'b1;
          state_next = HIGH;
        end
      end
      HIGH: begin
        cnt_inc = 1'b1;
        if (fall) begin
          hi_load    = 1'b1;
          state_next = LOW;
        end else if (cnt_full) begin
          overflow   = 1'b1;
          state_next = ARM;
        end
      end
      LOW: begin
        if (rise) begin
          report     = 1'b1;
          cnt_load   = 1'b1;
          state_next = HIGH;
        end else begin
          cnt_inc = 1'b1;
          if (cnt_full) begin
            overflow   = 1'b1;
            state_next = ARM;
          end
        end
      end
      default: state_next = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      hi_lat     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= report;
      if (cnt_load) begin
        cnt <= WIDTH'(1);
      end else if (cnt_inc) begin
        cnt <= cnt + WIDTH'(1);
      end
      if (hi_load) begin
        hi_lat <= cnt;
      end
      if (report) begin
        period    <= cnt;
        high_time <= hi_lat;
        locked    <= 1'b1;
        timeout   <= 1'b0;
      end else if (overflow) begin
        timeout <= 1'b1;
        locked  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blink_meter.sv
// Directed bench for blink_meter: 16-bit instance for the main scenarios and
// an 8-bit instance for the counter-overflow timeout.
module tb_blink_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        b16;
  logic        b8;
  logic [15:0] p16;
  logic [15:0] h16;
  logic        mv16;
  logic        lk16;
  logic        to16;
  logic [7:0]  p8;
  logic [7:0]  h8;
  logic        mv8;
  logic        lk8;
  logic        to8;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ph       = 0;
  int n_mv     = 0;
  int first_mv = -1;
  int last_mv  = -1;
  int base     = 0;
  int hold_mv  = 0;

  blink_meter #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
    .clk        (clk),
    .rst        (rst),
    .blink_in   (b16),
    .period     (p16),
    .high_time  (h16),
    .meas_valid (mv16),
    .locked     (lk16),
    .timeout    (to16)
  );

  blink_meter #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .blink_in   (b8),
    .period     (p8),
    .high_time  (h8),
    .meas_valid (mv8),
    .locked     (lk8),
    .timeout    (to8)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs set before step() are sampled at its edge; outputs read after it
  // reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_period16"},    int'(p16),  0);
    check_eq({tag, "_high16"},      int'(h16),  0);
    check_eq({tag, "_valid16"},     int'(mv16), 0);
    check_eq({tag, "_locked16"},    int'(lk16), 0);
    check_eq({tag, "_timeout16"},   int'(to16), 0);
    check_eq({tag, "_period8"},     int'(p8),   0);
    check_eq({tag, "_locked8"},     int'(lk8),  0);
    check_eq({tag, "_timeout8"},    int'(to8),  0);
  endtask

  task automatic apply_reset(input logic lvl, input int n);
    rst = 1'b1;
    b16 = lvl;
    b8  = lvl;
    repeat (n) step();
    check_zero("reset");
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    b16 = 1'b0;
    b8  = 1'b0;
    repeat (n) step();
  endtask

  task automatic start_meas(input int start_ph);
    n_mv     = 0;
    first_mv = -1;
    last_mv  = -1;
    base     = cyc;
    ph       = start_ph;
  endtask

  // Drives n cycles of a period-P / high-H wave and checks every report
  // against (ep,eh), or against either (ep,eh) or (ap,ah) when they differ.
  task automatic drive(input bit sel, input int P, input int H, input int n,
                       input int ep, input int eh, input int ap, input int ah,
                       input bit chk_space);
    int p;
    int h;
    int mv;
    int lk;
    int to;
    for (int i = 0; i < n; i++) begin
      if (sel) b8 = (ph < H);
      else     b16 = (ph < H);
      ph = (ph + 1 == P) ? 0 : ph + 1;
      step();
      mv = sel ? int'(mv8) : int'(mv16);
      p  = sel ? int'(p8)  : int'(p16);
      h  = sel ? int'(h8)  : int'(h16);
      lk = sel ? int'(lk8) : int'(lk16);
      to = sel ? int'(to8) : int'(to16);
      if (mv != 0) begin
        n_mv++;
        if (first_mv < 0) first_mv = cyc - base;
        if (ep == ap && eh == ah) begin
          check_eq("period", p, ep);
          check_eq("high_time", h, eh);
        end else begin
          check_eq("period_high_allowed",
                   int'((p == ep && h == eh) || (p == ap && h == ah)), 1);
        end
        check_eq("locked_on_report", lk, 1);
        check_eq("timeout_on_report", to, 0);
        if (chk_space && last_mv >= 0) check_eq("report_spacing", cyc - last_mv, P);
        last_mv = cyc;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    b16 = 1'b0;
    b8  = 1'b0;

    // 1: steady 10/3 after a low reset
    apply_reset(1'b0, 3);
    idle(5);
    start_meas(0);
    drive(1'b0, 10, 3, 60, 10, 3, 10, 3, 1'b1);
    check_eq("t1_first_latency", first_mv, 13);
    check_eq("t1_report_count", n_mv, 5);

    // 2: line high through reset must not produce a report
    apply_reset(1'b1, 3);
    hold_mv = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (mv16) hold_mv++;
    end
    check_eq("t2_no_report_while_high", hold_mv, 0);
    check_eq("t2_not_locked", int'(lk16), 0);
    start_meas(0);
    drive(1'b0, 8, 4, 50, 8, 4, 8, 4, 1'b1);
    check_eq("t2_first_latency", first_mv, 19);
    check_eq("t2_report_count", n_mv, 4);

    // 4: switch 10/3 -> 6/1 on a period boundary
    apply_reset(1'b0, 2);
    idle(5);
    start_meas(0);
    drive(1'b0, 10, 3, 40, 10, 3, 10, 3, 1'b1);
    drive(1'b0, 6, 1, 40, 6, 1, 10, 3, 1'b0);
    check_eq("t4_final_period", int'(p16), 6);
    check_eq("t4_final_high", int'(h16), 1);
    check_eq("t4_report_count", n_mv, 10);

    // 6: one-cycle pulses, period 4
    apply_reset(1'b0, 2);
    idle(5);
    start_meas(0);
    drive(1'b0, 4, 1, 40, 4, 1, 4, 1, 1'b1);
    check_eq("t6_first_latency", first_mv, 7);
    check_eq("t6_report_count", n_mv, 9);

    // 5: one-cycle reset while the meter is in HIGH
    apply_reset(1'b0, 2);
    idle(5);
    start_meas(0);
    drive(1'b0, 10, 3, 23, 10, 3, 10, 3, 1'b1);
    check_eq("t5_reports_before_reset", n_mv, 2);
    rst = 1'b1;
    drive(1'b0, 10, 3, 1, 10, 3, 10, 3, 1'b0);
    check_zero("t5_mid_reset");
    rst = 1'b0;
    start_meas(ph);
    drive(1'b0, 10, 3, 40, 10, 3, 10, 3, 1'b1);
    check_eq("t5_first_latency", first_mv, 19);
    check_eq("t5_report_count", n_mv, 3);

    // 3: WIDTH=8 overflow timeout, then recovery
    apply_reset(1'b0, 2);
    idle(5);
    start_meas(0);
    drive(1'b1, 10, 5, 40, 10, 5, 10, 5, 1'b1);
    check_eq("t3_lock_reports", n_mv, 3);
    b8 = 1'b1;
    hold_mv = 0;
    for (int j = 0; j < 300; j++) begin
      step();
      if (mv8) hold_mv++;
      if (j == 256) begin
        check_eq("t3_locked_before_ovf", int'(lk8), 1);
        check_eq("t3_timeout_before_ovf", int'(to8), 0);
      end
      if (j == 257) begin
        check_eq("t3_timeout_at_ovf", int'(to8), 1);
        check_eq("t3_locked_at_ovf", int'(lk8), 0);
      end
    end
    check_eq("t3_hold_reports", hold_mv, 1);
    check_eq("t3_period_kept", int'(p8), 10);
    check_eq("t3_high_kept", int'(h8), 5);
    check_eq("t3_timeout_sticky", int'(to8), 1);
    check_eq("t3_locked_cleared", int'(lk8), 0);
    start_meas(5);
    drive(1'b1, 10, 5, 30, 10, 5, 10, 5, 1'b1);
    check_eq("t3_recover_latency", first_mv, 18);
    check_eq("t3_timeout_cleared", int'(to8), 0);
    check_eq("t3_relocked", int'(lk8), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
